// File: rtl/sobel_gradient.sv
// sobel_gradient
//   Serial 3x3 Sobel engine. Takes the nine pixels of one window (raster
//   order p0..p8) over a valid/ready stream and accumulates Gx/Gy one pixel
//   per accept with shift/add coefficients. On p8 it issues the pair with a
//   one-cycle grad_start pulse and holds it while waiting for mag_done. If
//   mag_done does not arrive within TIMEOUT cycles, it abandons the handshake
//   and pulses timeout_err.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   pix_in/pix_valid  pixel stream in; pix_ready high while accumulating
//   gx, gy            signed 11-bit gradient pair, held until next window
//   grad_start        one-cycle pulse marking a new gx/gy pair
//   mag_done          completion level from the magnitude stage
//   busy              high while waiting on the magnitude stage
//   timeout_err       one-cycle pulse when the wait expires
module sobel_gradient #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic signed [10:0] gx,
  output logic signed [10:0] gy,
  output logic               grad_start,
  input  logic               mag_done,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic {ACCUM = 1'b0, WAIT = 1'b1} state_e;

  localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [11:0] accx_q, accx_d, accy_q, accy_d;
  logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
  logic               start_q, start_d;
  logic               terr_q, terr_d;
  logic [15:0]        wcnt_q, wcnt_d;

  // Coefficient terms: only x1 and x2 magnitudes appear, so a left shift
  // and negation cover the whole kernel.
  logic signed [11:0] px1, px2, dx, dy, sumx, sumy;

  assign px1 = signed'({4'b0000, pix_in});
  assign px2 = px1 <<< 1;

  always_comb begin
    dx = '0;
    dy = '0;
    case (cnt_q)
      4'd0:    begin dx = -px1; dy = -px1; end
      4'd1:    begin dx = '0;   dy = -px2; end
      4'd2:    begin dx = px1;  dy = -px1; end
      4'd3:    begin dx = -px2; dy = '0;   end
      4'd5:    begin dx = px2;  dy = '0;   end
      4'd6:    begin dx = -px1; dy = px1;  end
      4'd7:    begin dx = '0;   dy = px2;  end
      4'd8:    begin dx = px1;  dy = px1;  end
      default: begin dx = '0;   dy = '0;   end
    endcase
  end

  assign sumx = accx_q + dx;
  assign sumy = accy_q + dy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accx_d  = accx_q;
    accy_d  = accy_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    start_d = 1'b0;
    terr_d  = 1'b0;
    wcnt_d  = wcnt_q;
    case (state_q)
      ACCUM: begin
        if (pix_valid) begin
          if (cnt_q == 4'd8) begin
            gx_d    = sumx[10:0];
            gy_d    = sumy[10:0];
            start_d = 1'b1;
            accx_d  = '0;
            accy_d  = '0;
            cnt_d   = '0;
            wcnt_d  = '0;
            state_d = WAIT;
          end else begin
            accx_d = sumx;
            accy_d = sumy;
            cnt_d  = cnt_q + 4'd1;
          end
        end
      end
      WAIT: begin
        // mag_done at the edge closing the start pulse belongs to the
        // previous transaction's level and is not taken as completion.
        if (mag_done && !start_q) begin
          state_d = ACCUM;
        end else if (wcnt_q == WCNT_LAST) begin
          terr_d  = 1'b1;
          state_d = ACCUM;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      accx_q  <= '0;
      accy_q  <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      start_q <= 1'b0;
      terr_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      accx_q  <= accx_d;
      accy_q  <= accy_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      start_q <= start_d;
      terr_q  <= terr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pix_ready   = (state_q == ACCUM);
  assign busy        = (state_q == WAIT);
  assign gx          = gx_q;
  assign gy          = gy_q;
  assign grad_start  = start_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sobel_gradient.sv
module tb_sobel_gradient;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] pix_in = '0;
  logic pix_valid = 1'b0, pix_valid2 = 1'b0;
  logic mag_done = 1'b1, mag_done2 = 1'b0;
  logic pix_ready, grad_start, busy, timeout_err;
  logic pix_ready2, grad_start2, busy2, timeout_err2;
  logic signed [10:0] gx, gy, gx2, gy2;

  always #5 clk = ~clk;

  sobel_gradient dut (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .gx(gx), .gy(gy), .grad_start(grad_start),
    .mag_done(mag_done), .busy(busy), .timeout_err(timeout_err));

  sobel_gradient #(.TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid2),
    .pix_ready(pix_ready2), .gx(gx2), .gy(gy2), .grad_start(grad_start2),
    .mag_done(mag_done2), .busy(busy2), .timeout_err(timeout_err2));

  typedef struct { int gx; int gy; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, windows = 0, pulses = 0;
  int mag_mode = 0;   // 0: mag_done tied high, 1: fixed delay, 2: random 0..30
  int mag_delay = 0;
  logic [7:0] win [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plain Sobel sums straight from the kernel definition.
  task automatic sobel_ref(input logic [7:0] p [9], output int ex, output int ey);
    int q [9];
    for (int i = 0; i < 9; i++) q[i] = int'(p[i]);
    ex = (q[2] + 2*q[5] + q[8]) - (q[0] + 2*q[3] + q[6]);
    ey = (q[6] + 2*q[7] + q[8]) - (q[0] + 2*q[1] + q[2]);
  endtask

  // Returns at a falling edge with the pixel presented; it transfers at the
  // next rising edge.
  task automatic send_px(input logic [7:0] v, input bit gaps);
    int g = 0;
    forever begin
      @(negedge clk);
      pix_in = v;
      if (gaps && $urandom_range(3) == 0) pix_valid = 1'b0;
      else begin
        pix_valid = 1'b1;
        if (pix_ready) return;
      end
      g++;
      if (g > 200) begin
        chk("pix_ready_timeout", 0, 1);
        return;
      end
    end
  endtask

  // Ends 1 time unit after the edge that accepts p8.
  task automatic send_window(input bit gaps, input bit hold);
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      send_px(win[i], gaps);
      if (i == 8) begin
        sobel_ref(win, e.gx, e.gy);
        exp_q.push_back(e);
        windows++;
      end
    end
    @(posedge clk); #1;
    if (hold) pix_in = 8'd200;
    else pix_valid = 1'b0;
  endtask

  task automatic set_win(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    win[0] = 8'(a0); win[1] = 8'(a1); win[2] = 8'(a2);
    win[3] = 8'(a3); win[4] = 8'(a4); win[5] = 8'(a5);
    win[6] = 8'(a6); win[7] = 8'(a7); win[8] = 8'(a8);
  endtask

  // Monitor: every grad_start pops one expected pair.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (grad_start) begin
        pulses++;
        if (prev) chk("start_single_cycle", 1, 0);
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("gx", int'(gx), e.gx);
          chk("gy", int'(gy), e.gy);
        end
      end
      prev = grad_start;
    end
  end

  // Magnitude-stage responder.
  initial begin
    int d;
    forever begin
      @(posedge clk); #1;
      if (grad_start && mag_mode != 0) begin
        d = (mag_mode == 1) ? mag_delay : int'($urandom_range(30));
        repeat (d) @(negedge clk);
        @(negedge clk);
        mag_done = 1'b1;
        for (int k = 0; k < 100; k++) begin
          @(posedge clk); #1;
          if (!busy) break;
        end
        mag_done = 1'b0;
      end
    end
  end

  initial begin
    int waited, k, ex, ey;
    logic signed [10:0] gx0, gy0;
    exp_t e;

    #13;
    chk("reset_gx", int'(gx), 0);
    chk("reset_ready", int'(pix_ready), 1);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk) reset = 1'b0;

    // Uniform window, mag_done tied high.
    set_win(100, 100, 100, 100, 100, 100, 100, 100, 100);
    send_window(1'b0, 1'b0);
    chk("uni_start", int'(grad_start), 1);
    chk("uni_ready_low", int'(pix_ready), 0);
    @(posedge clk); #1;
    chk("uni_start_fall", int'(grad_start), 0);
    chk("uni_busy", int'(busy), 1);
    @(posedge clk); #1;
    chk("uni_ready_back", int'(pix_ready), 1);
    chk("uni_busy_low", int'(busy), 0);

    // Vertical and horizontal edges.
    set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
    send_window(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    set_win(255, 255, 255, 0, 0, 0, 0, 0, 0);
    send_window(1'b0, 1'b0);
    chk("hor_gy_bits", int'(gy[10:0]), 'h404);
    repeat (3) @(posedge clk);

    // Backpressure: mag_done answers after 20 cycles, pix_valid held high.
    mag_done = 1'b0;
    mag_mode = 1;
    mag_delay = 20;
    set_win(3, 9, 27, 81, 243, 5, 25, 125, 1);
    send_window(1'b0, 1'b1);
    gx0 = gx;
    gy0 = gy;
    waited = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!busy) break;
      waited++;
      if (pix_ready || gx != gx0 || gy != gy0) chk("bp_hold", 1, 0);
    end
    pix_valid = 1'b0;
    chk("bp_wait_len", int'(waited >= 20), 1);
    chk("bp_ready_back", int'(pix_ready), 1);
    set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
    send_window(1'b0, 1'b0);
    for (int c = 0; c < 60 && busy; c++) @(posedge clk);
    #1;

    // Reset after five accepted pixels.
    mag_mode = 2;
    for (int i = 0; i < 5; i++) send_px(8'(50 + i), 1'b0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_gx", int'(gx), 0);
    chk("rst_gy", int'(gy), 0);
    chk("rst_start", int'(grad_start), 0);
    chk("rst_ready", int'(pix_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_terr", int'(timeout_err), 0);
    @(negedge clk) reset = 1'b0;
    set_win(0, 0, 255, 0, 0, 255, 0, 0, 255);
    send_window(1'b1, 1'b0);
    for (int c = 0; c < 60 && busy; c++) @(posedge clk);
    #1;

    // Timeout on the TIMEOUT=8 instance; mag_done2 stays low.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(255));
      if (w == 0) set_win(7, 0, 0, 0, 0, 0, 0, 0, 200);
      sobel_ref(win, ex, ey);
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        pix_valid2 = 1'b1;
        pix_in = win[i];
      end
      @(posedge clk); #1;
      pix_valid2 = 1'b0;
      chk("to_start", int'(grad_start2), 1);
      chk("to_gx", int'(gx2), ex);
      chk("to_gy", int'(gy2), ey);
      k = 0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (timeout_err2) begin k = c; break; end
      end
      chk("to_cycles", k, 8);
      chk("to_state_accum", int'(pix_ready2), 1);
      chk("to_busy_low", int'(busy2), 0);
      @(posedge clk); #1;
      chk("to_pulse_single", int'(timeout_err2), 0);
      chk("to_gx_kept", int'(gx2), ex);
    end

    // Random windows with pixel gaps and random completion delays.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 9; i++) win[i] = 8'($urandom_range(255));
      send_window(1'b1, 1'b0);
    end

    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("pulse_count", pulses, windows);
    chk("no_main_timeout", int'(timeout_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
